// File: rtl/booth_pkg.sv
// Shared types, widths and the Booth digit slicer for the sequential multiplier.
package booth_pkg;

  localparam int OP_W     = 8;
  localparam int PROD_W   = 16;
  localparam int N_DIGITS = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t;

  // Returns {b[2c+1], b[2c], b[2c-1]}; the appended zero supplies b[-1].
  function automatic logic [2:0] booth_pattern(input logic [OP_W-1:0] b, input logic [1:0] c);
    logic [OP_W:0] ext;
    ext = {b, 1'b0};
    return ext[{c, 1'b0} +: 3];
  endfunction

endpackage

// File: rtl/booth_mul_seq_enc.sv
// Radix-4 Booth encoder: maps a 3-bit pattern to 0, +-m or +-2m, sign-extended to 16 bits.
// Combinational. The 16-bit path keeps -2*(-128)=256 from overflowing.
module booth_mul_seq_enc
  import booth_pkg::*;
(
  input  logic signed [OP_W-1:0]   m_i,
  input  logic        [2:0]        pattern_i,
  output logic signed [PROD_W-1:0] pp_o
);

  logic signed [PROD_W-1:0] m_ext;

  assign m_ext = {{(PROD_W-OP_W){m_i[OP_W-1]}}, m_i};

  always_comb begin
    pp_o = '0;
    case (pattern_i)
      3'b001, 3'b010: pp_o = m_ext;
      3'b011:         pp_o = m_ext <<< 1;
      3'b100:         pp_o = -(m_ext <<< 1);
      3'b101, 3'b110: pp_o = -m_ext;
      default:        pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative 8x8 signed radix-4 Booth multiplier, one digit per cycle; 1..4 cycles per product.
// Product is held in DONE until out_ready; a new operand can be taken on the same edge.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [OP_W-1:0]   b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [PROD_W-1:0] prod,
  output logic                     busy
);

  booth_state_t state_q, state_d;

  logic signed [OP_W-1:0]   a_q, b_q;
  logic signed [PROD_W-1:0] acc_q, acc_d;
  logic signed [PROD_W-1:0] prod_q;
  logic        [1:0]        cnt_q, cnt_d;

  logic        [2:0]        pattern;
  logic signed [PROD_W-1:0] pp;
  logic        [2:0]        shamt;
  logic signed [OP_W-1:0]   rest;
  logic                     last_digit;
  logic                     accept;

  booth_mul_seq_enc u_enc (
    .m_i       (a_q),
    .pattern_i (pattern),
    .pp_o      (pp)
  );

  assign pattern = booth_pattern(b_q, cnt_q);
  assign shamt   = {cnt_q, 1'b0};

  // Arithmetic shift leaves 0 or -1 exactly when b[7:2c+1] is uniform.
  assign rest       = b_q >>> (shamt + 3'd1);
  assign last_digit = (cnt_q == 2'(N_DIGITS-1)) ||
                      (EARLY_TERM && ((rest == '0) || (rest == '1)));

  assign acc_d  = acc_q + (pp <<< shamt);
  assign cnt_d  = cnt_q + 2'd1;
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (last_digit) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (last_digit) prod_q <= acc_d;
    end
  end

  assign prod = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench: two instances (EARLY_TERM=0 and =1), directed corners then random traffic.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid  [2];
  logic              in_ready  [2];
  logic              out_valid [2];
  logic              out_ready [2];
  logic              busy      [2];
  logic signed [7:0] a         [2];
  logic signed [7:0] b         [2];
  logic signed [15:0] prod     [2];

  booth_mul_seq #(.EARLY_TERM(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .prod(prod[0]), .busy(busy[0])
  );

  booth_mul_seq #(.EARLY_TERM(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .prod(prod[1]), .busy(busy[1])
  );

  typedef struct {
    int prod;
    int edge_no;
    int lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rdy_mode [2];   // 0: always ready, 1: random, 2: stalled

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s (dut%0d cycle %0d): got %0d, want %0d", name, 0, cyc, act, exp);
    end
  endtask

  // Digits needed: the smallest n for which b fits in 2n signed bits.
  function automatic int exp_lat(input int idx, input int bv);
    if (idx == 0) return 4;
    for (int n = 1; n <= 4; n++) begin
      int lim;
      lim = 1 << (2 * n - 1);
      if (bv >= -lim && bv < lim) return n;
    end
    return 4;
  endfunction

  function automatic int qsize(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int idx, input exp_t e);
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic qpop(input int idx, output exp_t e);
    if (idx == 0) e = q0.pop_front();
    else          e = q1.pop_front();
  endtask

  task automatic send(input int idx, input int av, input int bv, output int tries);
    bit   done;
    exp_t e;
    done  = 1'b0;
    tries = 0;
    while (!done) begin
      @(negedge clk);
      in_valid[idx] = 1'b1;
      a[idx]        = av[7:0];
      b[idx]        = bv[7:0];
      #1;
      tries++;
      if (in_ready[idx]) begin
        e.prod    = av * bv;
        e.edge_no = cyc + 1;
        e.lat     = exp_lat(idx, bv);
        qpush(idx, e);
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        done = 1'b1;
      end else if (tries > 200) begin
        check("send_timeout", 0, 1);
        in_valid[idx] = 1'b0;
        done = 1'b1;
      end
    end
  endtask

  task automatic drain(input int idx);
    int waited;
    waited = 0;
    while (qsize(idx) != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (qsize(idx) != 0) check("drain_timeout", qsize(idx), 0);
  endtask

  task automatic mon(input int idx);
    bit   prev_vld;
    bit   prev_fire;
    exp_t e;
    prev_vld  = 1'b0;
    prev_fire = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode[idx])
        0:       out_ready[idx] = 1'b1;
        1:       out_ready[idx] = ($urandom_range(0, 3) != 0);
        default: out_ready[idx] = 1'b0;
      endcase
      #2;
      if (out_valid[idx]) begin
        if (qsize(idx) == 0) begin
          check("unexpected_product", 1, 0);
          prev_fire = out_ready[idx];
        end else begin
          e = (idx == 0) ? q0[0] : q1[0];
          if (!prev_vld || prev_fire) check("latency", cyc - e.edge_no, e.lat);
          if (out_ready[idx]) begin
            check("prod", int'(prod[idx]), e.prod);
            qpop(idx, e);
            prev_fire = 1'b1;
          end else begin
            check("stall_prod", int'(prod[idx]), e.prod);
            check("stall_in_ready", int'(in_ready[idx]), 0);
            prev_fire = 1'b0;
          end
        end
      end else begin
        prev_fire = 1'b0;
      end
      prev_vld = out_valid[idx];
    end
  endtask

  task automatic rand_run(input int idx, input int n);
    int t;
    int av, bv;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      av = int'($urandom_range(0, 255)) - 128;
      bv = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 15) == 0) av = ($urandom_range(0, 1) != 0) ? -128 : 127;
      if ($urandom_range(0, 15) == 0) bv = ($urandom_range(0, 1) != 0) ? -128 : 127;
      send(idx, av, bv, t);
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      a[i]         = '0;
      b[i]         = '0;
      out_ready[i] = 1'b1;
      rdy_mode[i]  = 0;
    end
    fork
      mon(0);
      mon(1);
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      check("rst_out_valid", int'(out_valid[i]), 0);
      check("rst_prod", int'(prod[i]), 0);
      check("rst_in_ready", int'(in_ready[i]), 1);
      check("rst_busy", int'(busy[i]), 0);
    end
    rst = 1'b0;

    // Basic product, fixed 4-digit latency, valid for exactly one cycle.
    send(0, 3, 5, t);
    drain(0);
    @(negedge clk);
    #2;
    check("t1_valid_dropped", int'(out_valid[0]), 0);

    // Range extremes.
    send(0, -128, -128, t);
    send(0, 127, -128, t);
    send(0, -1, -1, t);
    drain(0);

    // Early termination: 1, 1 and 4 digits.
    send(1, 7, 1, t);
    send(1, 7, -1, t);
    send(1, 7, 64, t);
    send(1, -128, -128, t);
    drain(1);

    // Backpressure, then handshake and new accept on the same edge.
    rdy_mode[0] = 2;
    send(0, -5, 9, t);
    repeat (11) @(posedge clk);
    check("t4_held_valid", int'(out_valid[0]), 1);
    rdy_mode[0] = 0;
    send(0, 2, 2, t);
    check("t4_no_idle_accept", t, 1);
    drain(0);

    // Reset in the middle of digit 2 abandons the product.
    send(0, 3, 85, t);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q0.delete();
    @(posedge clk);
    #2;
    check("t5_busy", int'(busy[0]), 0);
    check("t5_out_valid", int'(out_valid[0]), 0);
    check("t5_prod", int'(prod[0]), 0);
    check("t5_in_ready", int'(in_ready[0]), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    send(0, -3, 4, t);
    drain(0);

    // Random traffic on both instances with throttled consumers.
    rdy_mode[0] = 1;
    rdy_mode[1] = 1;
    fork
      rand_run(0, 5000);
      rand_run(1, 5000);
    join
    drain(0);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
